shift_deserializer: RTL and testbench

- Receive-side counterpart of the 4-bit universal shift register used as a serializer. Collects a framed serial bit stream (one bit per strobe) into a WIDTH-bit parallel word.
- Supports LSB-first framing (matches the serializer's shift-right stream) and MSB-first framing (matches its shift-left stream).
- Presents each completed word on a 1-entry valid/ready output buffer for downstream logic.
- Sits between the serial link pins and the parallel consumer.

---
 rtl/shift_deser_pkg.sv | 15 +
 rtl/deser_out_buf.sv | 37 +++
 rtl/shift_deserializer.sv | 124 ++++++++++++
 tb/tb_shift_deserializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the shift deserializer.
package shift_deser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Direction encoding of msb_first and of the latched frame direction.
    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// A load is taken when the entry is empty or is being consumed this cycle;
// otherwise the load is refused and 'blocked' tells the caller why.
module deser_out_buf
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] pout,
    output logic             valid,
    output logic             blocked
);

    // Entry is full and the consumer is not taking it this cycle.
    assign blocked = valid && !ready;

    // Hold, refill (possibly in the same cycle as a consume) or drain the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the data register is reset too, not just valid, so Pout reads 0 out of reset.
            pout  <= '0;
            valid <= 1'b0;
        end else if (load && !blocked) begin
            pout  <= data;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Framed serial-to-parallel receiver. Collects WIDTH bits (LSB- or MSB-first,
// direction latched with the first bit) and hands each completed word to a
// one-entry valid/ready buffer, flagging dropped words and aborted frames.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clck,
    input  logic             reset,
    input  logic             Sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    input  logic             msb_first,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] Pout,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_abort
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shift_base;
    logic [WIDTH-1:0] sreg_next;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             dir_next;
    logic             complete;
    logic             blocked;

    // Next shift-register value for an accepted bit; a frame_start bit
    // shifts into a cleared register so no stale partial bits survive.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        shift_base = sreg;
        dir_next   = dir;
        if (frame_start) begin
            shift_base = '0;
        end
        if (state == ST_IDLE || frame_start) begin
            dir_next = msb_first;
        end
        if (dir_next == DIR_MSB) begin
            sreg_next = {shift_base[WIDTH-2:0], Sin};
        end else begin
            sreg_next = {Sin, shift_base[WIDTH-1:1]};
        end
    end

    // The bit that fills the last position of a frame in progress.
    assign complete = (state == ST_SHIFT) && sin_valid && !frame_start
                      && (count == CNT_W'(WIDTH - 1));

    // Frame FSM with bit counter, shift register and abort pulse.
    always_ff @(posedge Clck or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sreg        <= '0;
            count       <= '0;
            dir         <= DIR_LSB;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sin_valid && frame_start) begin
                        dir   <= dir_next;
                        sreg  <= sreg_next;
                        count <= CNT_W'(1);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sin_valid) begin
                        dir  <= dir_next;
                        sreg <= sreg_next;
                        if (frame_start) begin
                            frame_abort <= 1'b1;
                            count       <= CNT_W'(1);
                        end else if (complete) begin
                            count <= '0;
                            state <= ST_IDLE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);

    // Sticky overrun: a completed word met a full, unconsumed buffer.
    always_ff @(posedge Clck or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (complete && blocked) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    deser_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk    (Clck),
        .rst_n  (reset),
        .load   (complete),
        .data   (sreg_next),
        .ready  (out_ready),
        .pout   (Pout),
        .valid  (out_valid),
        .blocked(blocked)
    );

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: table of single frames plus hand-written
// multi-cycle sequences; words are checked through an expected-word queue.
module tb_shift_deserializer;

    logic       Clck = 1'b0;
    logic       reset = 1'b0;
    logic       Sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       msb_first = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [3:0] Pout;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic       frame_abort;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];

    typedef struct {
        logic       msb;
        logic [3:0] bits;   // bits[0] is sent first
        logic [3:0] word;
    } vec_t;

    vec_t vecs[6];

    shift_deserializer #(.WIDTH(4)) dut (
        .Clck       (Clck),
        .reset      (reset),
        .Sin        (Sin),
        .sin_valid  (sin_valid),
        .frame_start(frame_start),
        .msb_first  (msb_first),
        .out_ready  (out_ready),
        .clr_ovr    (clr_ovr),
        .Pout       (Pout),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun),
        .frame_abort(frame_abort)
    );

    always #5 Clck = ~Clck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clck);
        #2;
    endtask

    task automatic send_bit(input logic fs, input logic b, input logic msb);
        sin_valid   = 1'b1;
        frame_start = fs;
        Sin         = b;
        msb_first   = msb;
        tick();
        sin_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic msb, input logic [3:0] bits);
        for (int i = 0; i < 4; i++) begin
            send_bit(i == 0, bits[i], msb);
        end
    endtask

    // Scoreboard: every handshake seen mid-cycle must match the oldest expected word.
    always @(negedge Clck) begin
        if (reset && out_valid && out_ready) begin
            check("sb_word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("sb_pout", Pout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{msb: 1'b0, bits: 4'b1101, word: 4'hD}; // 1,0,1,1 LSB-first
        vecs[1] = '{msb: 1'b1, bits: 4'b1101, word: 4'hB}; // 1,0,1,1 MSB-first
        vecs[2] = '{msb: 1'b0, bits: 4'b0011, word: 4'h3}; // 1,1,0,0 LSB-first
        vecs[3] = '{msb: 1'b1, bits: 4'b0011, word: 4'hC}; // 1,1,0,0 MSB-first
        vecs[4] = '{msb: 1'b1, bits: 4'b1000, word: 4'h1}; // 0,0,0,1 MSB-first
        vecs[5] = '{msb: 1'b0, bits: 4'b0110, word: 4'h6}; // 0,1,1,0 LSB-first

        // Reset state
        #1;
        check("rst_pout", Pout, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_abort", frame_abort, 0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();

        // Table: one frame each, 1-cycle latency, single-cycle valid
        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k].word);
            for (int i = 0; i < 3; i++) begin
                send_bit(i == 0, vecs[k].bits[i], vecs[k].msb);
            end
            check("vec_busy_mid", busy, 1);
            check("vec_valid_before", out_valid, 0);
            send_bit(1'b0, vecs[k].bits[3], vecs[k].msb);
            check("vec_valid_after", out_valid, 1);
            check("vec_busy_done", busy, 0);
            tick();
            check("vec_valid_drop", out_valid, 0);
        end

        // Direction change mid-frame is ignored: 0,1,1,0 MSB-first -> 6
        exp_q.push_back(4'h6);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        check("dir_hold_valid", out_valid, 1);
        tick();

        // Restart: 2 bits, then frame_start + 0,0,0,1 LSB-first -> 8
        exp_q.push_back(4'h8);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("abort_idle", frame_abort, 0);
        send_bit(1'b1, 1'b0, 1'b0);
        check("abort_pulse", frame_abort, 1);
        send_bit(1'b0, 1'b0, 1'b0);
        check("abort_single", frame_abort, 0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("abort_valid", out_valid, 1);
        check("abort_busy", busy, 0);
        tick();

        // Backpressure: 0x3 held, 0x5 dropped, overrun sticky until cleared
        out_ready = 1'b0;
        exp_q.push_back(4'h3);
        send_frame(1'b0, 4'b0011);
        send_frame(1'b0, 4'b0101);
        check("bp_overrun", overrun, 1);
        check("bp_valid", out_valid, 1);
        check("bp_pout_held", Pout, 4'h3);
        out_ready = 1'b1;
        tick();
        check("bp_valid_fall", out_valid, 0);
        check("bp_overrun_sticky", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("bp_overrun_clr", overrun, 0);

        // Back-to-back frames with consume, no gap between frames
        exp_q.push_back(4'h9);
        exp_q.push_back(4'h4);
        send_frame(1'b0, 4'b1001);
        check("b2b_valid1", out_valid, 1);
        send_frame(1'b1, 4'b0010);
        check("b2b_valid2", out_valid, 1);
        check("b2b_overrun", overrun, 0);
        tick();

        // Same-cycle consume and refill: ready rises on the completing edge
        out_ready = 1'b0;
        exp_q.push_back(4'hA);
        exp_q.push_back(4'h5);
        send_frame(1'b0, 4'b1010);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        check("refill_valid", out_valid, 1);
        check("refill_pout", Pout, 4'h5);
        check("refill_overrun", overrun, 0);
        tick();
        check("refill_drain", out_valid, 0);

        // Async reset mid-frame with a held word and overrun set
        out_ready = 1'b0;
        send_frame(1'b0, 4'b1111);
        send_frame(1'b0, 4'b0001);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_overrun", overrun, 1);
        reset = 1'b0;
        #1;
        check("arst_pout", Pout, 0);
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("stray_busy", busy, 0);
        check("stray_valid", out_valid, 0);
        exp_q.push_back(4'hA);
        send_frame(1'b0, 4'b1010);
        check("post_rst_valid", out_valid, 1);
        tick();
        tick();

        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
